trap_controller: RTL
====================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port instr_valid, input, 1, instruction presented this cycle by execute stage.
REQ-004 SHALL have port instr_pc, input, 32, PC of the presented instruction.
REQ-005 SHALL have port instr_word, input, 32, encoding of the presented instruction.
REQ-006 SHALL have port mem_addr, input, 32, effective load/store or fetch target address.
REQ-007 SHALL have port exc_req, input, 6, one-hot flags {store_mis, load_mis, ecall, ebreak, illegal, fetch_mis} in bits [5:0].
REQ-008 SHALL have port mret_req, input, 1, presented instruction is MRET.
REQ-009 SHALL have ports timer_int and ext_int, input, 1 each, pending interrupts from the CSR block.
REQ-010 SHALL have port mie, input, 1, global interrupt enable.
REQ-011 SHALL have ports mtvec and mepc, input, 32 each, current CSR values.
REQ-012 SHALL have port pipe_empty, input, 1, all older in-flight operations retired.
REQ-013 SHALL have ports stall and flush, output, 1 each, freeze fetch and kill younger instructions.
REQ-014 SHALL have ports exc_taken and mret_taken, output, 1 each, single-cycle commit pulses to the CSR block.
REQ-015 SHALL have ports exc_cause (4), exc_int (1), exc_pc (32) and exc_tval (32), output, trap record held stable while exc_taken is high.
REQ-016 SHALL have ports redirect_valid (1) and redirect_pc (32), output, single-cycle fetch redirect.

Function
REQ-017 SHALL implement FSM IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE.
REQ-018 SHALL, in IDLE with instr_valid=1, select the event by priority: fetch_mis > illegal > ebreak > ecall > load_mis > store_mis > mret_req > ext_int > timer_int.
REQ-019 SHALL qualify interrupts by mie=1 and instr_valid=1; pending interrupts SHALL be ignored when mie=0.
REQ-020 SHALL encode exc_cause as follows: fetch_mis=0, illegal=2, ebreak=3, load_mis=4, store_mis=6, ecall=11, timer=7, ext=11. exc_int SHALL be 1 only for interrupts.
REQ-021 SHALL source exc_tval as follows: illegal -> instr_word; fetch_mis, load_mis and store_mis -> mem_addr; all other events -> 0.
REQ-022 SHALL set exc_pc to instr_pc for every event; for interrupts, the trapped instruction SHALL NOT execute.
REQ-023 SHALL, on event acceptance, latch cause, int, pc, tval and kind (trap or mret) into registers, and enter DRAIN on the next edge.
REQ-024 SHALL assert stall and flush in DRAIN, COMMIT and REDIRECT, and SHALL deassert both in IDLE.
REQ-025 SHALL remain in DRAIN while pipe_empty=0; pipe_empty=1 SHALL cause a move to COMMIT.
REQ-026 SHALL, in COMMIT, pulse exactly one of exc_taken or mret_taken for exactly 1 cycle.
REQ-027 SHALL, in REDIRECT, pulse redirect_valid for 1 cycle with redirect_pc = {mtvec[31:2],2'b00} for a trap, or mepc for MRET, sampled in that cycle.
REQ-028 SHALL provide minimum latency of acceptance edge N -> exc_taken in cycle N+2 -> redirect_valid in cycle N+3.
REQ-029 SHALL ignore all requests while not in IDLE; there SHALL be no queuing and no nested traps.
REQ-030 SHALL give simultaneous mret_req and any exc_req bit to the exception, and SHALL generate no mret_taken in that case.
REQ-031 SHALL treat instr_valid=0 as no event, regardless of the flags.

Reset
REQ-032 SHALL, with rst_n=0 at a clock edge, force state IDLE and drive all outputs and latched records to 0, including redirect_pc.
REQ-033 SHALL, on reset mid-sequence, abandon the sequence with no exc_taken, mret_taken or redirect pulse afterwards.

Structure
REQ-034 SHALL place state encoding, cause code constants and exc_req bit indices in shared package trap_pkg.
REQ-035 SHALL implement event selection as combinational sub-module trap_prio_encoder, which produces valid, cause, int and kind.

Verification
REQ-036 SHALL verify: illegal at pc=0x80, instr_word=0xFFFFFFFF, pipe_empty=1 -> exc_taken at N+2, cause=2, tval=0xFFFFFFFF; redirect_pc=0x100 at N+3.
REQ-037 SHALL verify: mret_req with mepc=0x84 -> mret_taken 1 cycle, exc_taken never high; redirect_pc=0x84.
REQ-038 SHALL verify: timer_int=1 with mie=0 -> no trap; mie=1 -> cause=7, exc_int=1, exc_pc=instr_pc.
REQ-039 SHALL verify: ecall with ext_int=1 and mie=1 -> cause=11, exc_int=0; pipe_empty held 0 for 5 cycles -> exc_taken delayed to N+7.
REQ-040 SHALL verify: rst_n=0 asserted in DRAIN -> IDLE next cycle, stall=0, no pulses; a new request thereafter is accepted normally.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the trap controller: FSM states, event kinds,
// exc_req bit positions and mcause codes.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT
    } state_e;

    typedef enum logic {
        KIND_TRAP,
        KIND_MRET
    } kind_e;

    localparam int EXC_FETCH_MIS = 0;
    localparam int EXC_ILLEGAL   = 1;
    localparam int EXC_EBREAK    = 2;
    localparam int EXC_ECALL     = 3;
    localparam int EXC_LOAD_MIS  = 4;
    localparam int EXC_STORE_MIS = 5;

    localparam logic [3:0] CAUSE_FETCH_MIS = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MIS  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MIS = 4'd6;
    localparam logic [3:0] CAUSE_ECALL     = 4'd11;
    localparam logic [3:0] CAUSE_TIMER     = 4'd7;
    localparam logic [3:0] CAUSE_EXT       = 4'd11;

    // Misaligned accesses report the faulting address, illegal reports the encoding.
    function automatic logic [31:0] select_tval(input logic        irq,
                                                input logic [3:0]  cause,
                                                input logic [31:0] word,
                                                input logic [31:0] addr);
        logic [31:0] tval;
        tval = '0;
        if (!irq) begin
            case (cause)
                CAUSE_FETCH_MIS, CAUSE_LOAD_MIS, CAUSE_STORE_MIS: tval = addr;
                CAUSE_ILLEGAL:                                    tval = word;
                default:                                          tval = '0;
            endcase
        end
        return tval;
    endfunction

endpackage

// File: rtl/trap_prio_encoder.sv
// Combinational selection of the single highest-priority event presented
// by the execute stage.
module trap_prio_encoder
    import trap_pkg::*;
(
    input  logic       instr_valid,
    input  logic [5:0] exc_req,
    input  logic       mret_req,
    input  logic       timer_int,
    input  logic       ext_int,
    input  logic       mie,
    output logic       valid,
    output logic [3:0] cause,
    output logic       irq,
    output kind_e      kind
);

    always_comb begin
        valid = 1'b0;
        cause = '0;
        irq   = 1'b0;
        kind  = KIND_TRAP;
        if (instr_valid) begin
            if (exc_req[EXC_FETCH_MIS]) begin
                valid = 1'b1;
                cause = CAUSE_FETCH_MIS;
            end else if (exc_req[EXC_ILLEGAL]) begin
                valid = 1'b1;
                cause = CAUSE_ILLEGAL;
            end else if (exc_req[EXC_EBREAK]) begin
                valid = 1'b1;
                cause = CAUSE_EBREAK;
            end else if (exc_req[EXC_ECALL]) begin
                valid = 1'b1;
                cause = CAUSE_ECALL;
            end else if (exc_req[EXC_LOAD_MIS]) begin
                valid = 1'b1;
                cause = CAUSE_LOAD_MIS;
            end else if (exc_req[EXC_STORE_MIS]) begin
                valid = 1'b1;
                cause = CAUSE_STORE_MIS;
            end else if (mret_req) begin
                valid = 1'b1;
                kind  = KIND_MRET;
            end else if (mie && ext_int) begin
                valid = 1'b1;
                cause = CAUSE_EXT;
                irq   = 1'b1;
            end else if (mie && timer_int) begin
                valid = 1'b1;
                cause = CAUSE_TIMER;
                irq   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Trap/MRET sequencer: accepts one event, drains the pipe, commits to the
// CSR block for one cycle, then redirects fetch for one cycle.
module trap_controller
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr_pc,
    input  logic [31:0] instr_word,
    input  logic [31:0] mem_addr,
    input  logic [5:0]  exc_req,
    input  logic        mret_req,
    input  logic        timer_int,
    input  logic        ext_int,
    input  logic        mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        pipe_empty,
    output logic        stall,
    output logic        flush,
    output logic        exc_taken,
    output logic        mret_taken,
    output logic [3:0]  exc_cause,
    output logic        exc_int,
    output logic [31:0] exc_pc,
    output logic [31:0] exc_tval,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    state_e      state;
    kind_e       rec_kind;
    logic        ev_valid;
    logic [3:0]  ev_cause;
    logic        ev_irq;
    kind_e       ev_kind;
    logic [31:0] ev_tval;

    trap_prio_encoder u_prio (
        .instr_valid (instr_valid),
        .exc_req     (exc_req),
        .mret_req    (mret_req),
        .timer_int   (timer_int),
        .ext_int     (ext_int),
        .mie         (mie),
        .valid       (ev_valid),
        .cause       (ev_cause),
        .irq         (ev_irq),
        .kind        (ev_kind)
    );

    assign ev_tval = (ev_kind == KIND_MRET) ? '0
                   : select_tval(ev_irq, ev_cause, instr_word, mem_addr);

    // Target CSRs are read in the redirect cycle itself so a same-cycle CSR update is seen.
    assign redirect_pc = !redirect_valid        ? '0
                       : (rec_kind == KIND_MRET) ? mepc
                       :                           (mtvec & 32'hFFFF_FFFC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rec_kind       <= KIND_TRAP;
            stall          <= 1'b0;
            flush          <= 1'b0;
            exc_taken      <= 1'b0;
            mret_taken     <= 1'b0;
            exc_cause      <= '0;
            exc_int        <= 1'b0;
            exc_pc         <= '0;
            exc_tval       <= '0;
            redirect_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stall          <= 1'b0;
                    flush          <= 1'b0;
                    exc_taken      <= 1'b0;
                    mret_taken     <= 1'b0;
                    redirect_valid <= 1'b0;
                    if (ev_valid) begin
                        state     <= ST_DRAIN;
                        rec_kind  <= ev_kind;
                        exc_cause <= ev_cause;
                        exc_int   <= ev_irq;
                        exc_pc    <= instr_pc;
                        exc_tval  <= ev_tval;
                        stall     <= 1'b1;
                        flush     <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        state      <= ST_COMMIT;
                        exc_taken  <= (rec_kind == KIND_TRAP);
                        mret_taken <= (rec_kind == KIND_MRET);
                    end
                end
                ST_COMMIT: begin
                    state          <= ST_REDIRECT;
                    exc_taken      <= 1'b0;
                    mret_taken     <= 1'b0;
                    redirect_valid <= 1'b1;
                end
                ST_REDIRECT: begin
                    state          <= ST_IDLE;
                    redirect_valid <= 1'b0;
                    stall          <= 1'b0;
                    flush          <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
